// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and constants for the serial link transmitter and receiver
package serial_pkg;

    // Frame phases: start bit, data bits LSB first, optional parity, stop bit.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } tx_state_e;

    // Line levels: the line idles high so a pulled-up pad reads as idle.
    localparam logic TX_IDLE  = 1'b1;
    localparam logic TX_START = 1'b0;

    // Number of bit periods in one frame: start + data + parity + stop.
    function automatic int frame_bits(input int width, input int parity);
        return 2 + width + parity;
    endfunction

endpackage

// File: rtl/serial_tx_bit_timer.sv
// rtl/serial_tx_bit_timer.sv - bit-period counter shared by the serial transmitter and receiver
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the bit period from zero (frame start)
//   enable     : count this clock
//   bit_end    : high on the last clock of the current bit period
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign bit_end = enable && (cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            // Wrap on the last clock so the next bit starts at zero.
            cnt <= bit_end ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - parallel-to-serial frame transmitter (start, data LSB first, optional even parity, stop)
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   data       : word to send, sampled only when accepted
//   valid      : producer offers data
//   ready      : transmitter can accept (IDLE only)
//   tx         : serial line, idle/stop = 1, start = 0
//   busy       : frame in progress
module serial_tx
    import serial_pkg::*;
#(
    parameter int WIDTH        = 9,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY       = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic             ready,
    output logic             tx,
    output logic             busy
);

    localparam int IDX_W = $clog2(WIDTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    tx_state_e        state;
    tx_state_e        state_next;
    logic [WIDTH-1:0] shreg;
    logic [IDX_W-1:0] bit_idx;
    logic             par_bit;
    logic             accept;
    logic             bit_end;

    assign accept = valid && (state == IDLE);

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept),
        .enable (state != IDLE),
        .bit_end(bit_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outputs decode only the registered state and datapath, never valid or
    // data, so reset forces tx high immediately through the state register.
    always_comb begin
        state_next = state;
        tx         = TX_IDLE;
        ready      = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
                if (accept) begin
                    state_next = START;
                end
            end
            START: begin
                tx = TX_START;
                if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                tx = shreg[0];
                if (bit_end && (bit_idx == LAST_IDX)) begin
                    state_next = (PARITY != 0) ? PAR : STOP;
                end
            end
            PAR: begin
                tx = par_bit;
                if (bit_end) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                tx = TX_IDLE;
                if (bit_end) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The shift register consumes the word, so parity is taken from the
    // word as it is latched and held for the parity bit period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_idx <= '0;
            par_bit <= 1'b0;
        end else if (accept) begin
            shreg   <= data;
            bit_idx <= '0;
            par_bit <= ^data;
        end else if ((state == DATA) && bit_end) begin
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 1'b1;
        end
    end

endmodule

// File: doc/serial_tx.md
# serial_tx

Parallel-to-serial frame transmitter: accepts one WIDTH-bit word per valid/ready handshake and shifts it out on a single line as start bit, data bits LSB first, optional even-parity bit, and stop bit. Each bit is held for CLKS_PER_BIT clocks. It is the transmit end of the serial link whose receive end deserializes the same 9-bit frames. It sits between the register-level producer and the pad; tx idles high, suiting a pulled-up line.

## Interface
- WIDTH, 9, data bits per frame (≥1)
- CLKS_PER_BIT, 4, clocks each bit is held on tx (≥1)
- PARITY, 0, 0 = no parity bit, 1 = even parity bit after the data bits
- clk  in  1  sole clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- data  in  WIDTH  word to send, sampled only at acceptance
- valid  in  1  producer offers data
- ready  out  1  transmitter can accept; high only in IDLE
- tx  out  1  serial line, idle/stop = 1, start = 0
- busy  out  1  frame in progress (any state except IDLE)

## Operation
- States: IDLE, START, DATA, PAR, STOP.
- IDLE: tx=1, ready=1, busy=0. Acceptance is valid && ready at a rising edge. On acceptance, latch data into the shift register, clear the bit and clock counters, and go to START.
- START: tx=0 for CLKS_PER_BIT clocks, then go to DATA.
- DATA: tx = shreg[0]. At the end of each bit period, shift right and increment the bit index. After WIDTH bits, go to PAR if PARITY=1, else STOP.
- PAR: tx = XOR of the latched word (even parity: total ones including the parity bit is even). Held for CLKS_PER_BIT, then go to STOP.
- STOP: tx=1 for CLKS_PER_BIT clocks, then go to IDLE.
- Clock counter runs 0..CLKS_PER_BIT-1. Bit end is when the counter equals CLKS_PER_BIT-1, and the counter wraps to 0. The counter is $clog2(CLKS_PER_BIT+1) bits wide. CLKS_PER_BIT=1 is legal: one clock per bit.
- Parity is computed from the latched copy, not live data. Changes to data or valid after acceptance have no effect.
- A valid that drops before acceptance is legal; nothing is sent.
- valid held high continuously sends frames back to back, separated by exactly one IDLE clock.
- Reset values (async, rst_n=0): state=IDLE, tx=1, ready=1, busy=0, shreg=0, counters=0.
- Reset mid-frame aborts the frame immediately; tx goes to 1 without waiting for a clock edge, and the partial frame is not resumed.

## Timing
- tx, ready and busy are registered-state decodes with no combinational path from valid or data.
- Acceptance edge at cycle N: tx=0 from cycle N+1. The start bit occupies cycles N+1..N+CLKS_PER_BIT.
- Frame length is F = (2 + WIDTH + PARITY) × CLKS_PER_BIT clocks. The last stop-bit clock is N+F, IDLE (ready=1) resumes at N+F+1, and the earliest next acceptance is at that edge.
- ready falls in cycle N+1 and busy rises in cycle N+1.
- Data bit k occupies cycles N+1+(k+1)·CLKS_PER_BIT through N+(k+2)·CLKS_PER_BIT.

## Structure
- Package serial_pkg holds:
  - the state enum (IDLE, START, DATA, PAR, STOP);
  - the TX_IDLE=1 and TX_START=0 constants;
  - the function frame_bits(WIDTH, PARITY), shared with the receiver.
- One sub-module, bit_timer: the CLKS_PER_BIT counter with inputs clear and enable and output bit_end. It is reused by the receiver.
- All remaining logic is in serial_tx: the FSM, the shift register, the bit index and parity.

## Test plan
- Reset and idle: hold rst_n=0 for 3 clocks, then release. Require tx=1, ready=1 and busy=0, and tx stays 1 for 20 clocks with valid=0.
- Single frame (WIDTH=9, CLKS_PER_BIT=4, PARITY=0): send data=9'h1A5. tx per 4-clock bit must read 0,1,0,1,0,0,1,0,1,1,1, 44 clocks total, with ready=1 again at clock 45 after acceptance.
- Parity (PARITY=1): send data=9'h1A5. The parity bit is 1 (five ones), the frame is 48 clocks, and the bit sequence ends …,1,1,1,1.
- Back-to-back: hold valid=1 with data=9'h000 then 9'h1FF. Require exactly one idle-high clock between the first stop bit and the second start bit, and the second frame carries all-ones data.
- Data stability: change data from 9'h055 to 9'h0AA the clock after acceptance. The line must still carry 9'h055.
- Mid-frame reset and CLKS_PER_BIT=1: assert rst_n=0 during data bit 3. Require tx=1 asynchronously and a new frame accepted cleanly after release. Separately, with CLKS_PER_BIT=1, data=9'h001 yields 0,1,0×8,1 over 11 clocks.
